// File: rtl/miner_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module : miner_feeder_pkg
// Brief  : Shared widths, FSM state encoding and queue record types for the
//          miner work feeder.
// Rev    : 1.0  initial release
// ============================================================================
package miner_feeder_pkg;

  localparam int MIDSTATE_W = 256;
  localparam int DATA_W     = 96;
  localparam int NONCE_W    = 32;
  localparam int TAG_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MINE = 2'd2
  } state_t;

  typedef struct packed {
    logic [MIDSTATE_W-1:0] midstate;
    logic [DATA_W-1:0]     data;
  } work_t;

  typedef struct packed {
    logic [NONCE_W-1:0] nonce;
    logic [TAG_W-1:0]   tag;
    logic               exhausted;
  } result_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/miner_work_feeder_fifo.sv
`default_nettype none
// ============================================================================
// Module : feeder_fifo
// Brief  : Synchronous FIFO, registered storage, full/empty flags, clear.
// Rev    : 1.0  initial release
// ============================================================================
module feeder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int              c_aw       = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_full_cnt = (c_aw+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == c_full_cnt);
  assign dout  = r_mem[r_rd_ptr];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/miner_work_feeder.sv
`default_nettype none
// ============================================================================
// Module : miner_work_feeder
// Brief  : Queues host work, loads it into the miner one unit at a time and
//          collects golden-nonce / exhausted reports for the host.
//          MINER_FEEDER_STATS_EN adds n_loaded / n_found counters.
// Rev    : 1.0  initial release
// ============================================================================
module miner_work_feeder
  import miner_feeder_pkg::*;
#(
  parameter int WORK_DEPTH = 4,
  parameter int RES_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [MIDSTATE_W-1:0] w_midstate,
  input  logic [DATA_W-1:0]     w_data,
  output logic                  m_load,
  output logic [MIDSTATE_W-1:0] m_midstate,
  output logic [DATA_W-1:0]     m_data,
  output logic [TAG_W-1:0]      m_tag,
  input  logic                  m_found,
  input  logic [NONCE_W-1:0]    m_nonce,
  input  logic                  m_wrap,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [NONCE_W-1:0]    r_nonce,
  output logic [TAG_W-1:0]      r_tag,
  output logic                  r_exhausted,
`ifdef MINER_FEEDER_STATS_EN
  output logic [31:0]           n_loaded,
  output logic [31:0]           n_found,
`endif
  output logic [7:0]            r_overflow
);

  state_t                r_state;
  state_t                w_next;
  logic [MIDSTATE_W-1:0] r_midstate;
  logic [DATA_W-1:0]     r_data;
  logic [TAG_W-1:0]      r_cur_tag;
  logic [TAG_W-1:0]      r_tag_cnt;
  logic [7:0]            r_ovf;

  work_t   w_wq_dout;
  work_t   w_wq_din;
  work_t   w_src;
  logic    w_wq_full;
  logic    w_wq_empty;
  logic    w_wq_push;
  logic    w_wq_pop;
  result_t w_rq_dout;
  result_t w_rq_din;
  logic    w_rq_full;
  logic    w_rq_empty;
  logic    w_rq_push;
  logic    w_rq_pop;

  logic    w_accept;
  logic    w_work_avail;
  logic    w_report;
  logic    w_take;
  logic    w_drop;

  assign w_accept     = w_valid && !w_wq_full;
  assign w_work_avail = !w_wq_empty || w_accept;
  assign w_wq_din     = '{midstate: w_midstate, data: w_data};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_work_avail) w_next = LOAD;
      LOAD: w_next = MINE;
      MINE: if (m_found || m_wrap) w_next = w_work_avail ? LOAD : IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) begin
      w_next = IDLE;
    end
  end

  // Work arriving while the queue is empty bypasses it straight into the
  // miner registers so that LOAD follows the accepting edge directly.
  assign w_take    = (w_next == LOAD);
  assign w_wq_pop  = w_take && !w_wq_empty;
  assign w_wq_push = w_accept && !flush && !(w_take && w_wq_empty);
  assign w_src     = w_wq_empty ? w_wq_din : w_wq_dout;

  assign w_report  = (r_state == MINE) && (m_found || m_wrap) && !flush;
  assign w_rq_din  = '{nonce:     m_found ? m_nonce : '0,
                       tag:       r_cur_tag,
                       exhausted: !m_found};
  assign w_rq_pop  = r_ready && !w_rq_empty;
  assign w_rq_push = w_report && (!w_rq_full || w_rq_pop);
  assign w_drop    = w_report && w_rq_full && !w_rq_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_midstate <= '0;
      r_data     <= '0;
      r_cur_tag  <= '0;
      r_tag_cnt  <= '0;
      r_ovf      <= '0;
    end else begin
      if (w_take) begin
        r_midstate <= w_src.midstate;
        r_data     <= w_src.data;
        r_cur_tag  <= r_tag_cnt;
        r_tag_cnt  <= r_tag_cnt + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= sat_inc8(r_ovf);
      end
    end
  end

`ifdef MINER_FEEDER_STATS_EN
  logic [31:0] r_n_loaded;
  logic [31:0] r_n_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_loaded <= '0;
      r_n_found  <= '0;
    end else begin
      if (w_take) begin
        r_n_loaded <= r_n_loaded + 1'b1;
      end
      if (w_rq_push && m_found) begin
        r_n_found <= r_n_found + 1'b1;
      end
    end
  end

  assign n_loaded = r_n_loaded;
  assign n_found  = r_n_found;
`endif

  feeder_fifo #(
    .WIDTH ($bits(work_t)),
    .DEPTH (WORK_DEPTH)
  ) u_work_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (w_wq_push),
    .din   (w_wq_din),
    .pop   (w_wq_pop),
    .dout  (w_wq_dout),
    .full  (w_wq_full),
    .empty (w_wq_empty)
  );

  feeder_fifo #(
    .WIDTH ($bits(result_t)),
    .DEPTH (RES_DEPTH)
  ) u_res_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .push  (w_rq_push),
    .din   (w_rq_din),
    .pop   (w_rq_pop),
    .dout  (w_rq_dout),
    .full  (w_rq_full),
    .empty (w_rq_empty)
  );

  assign w_ready     = !w_wq_full;
  assign m_load      = (r_state == LOAD);
  assign m_midstate  = r_midstate;
  assign m_data      = r_data;
  assign m_tag       = r_cur_tag;
  assign r_valid     = !w_rq_empty;
  assign r_nonce     = w_rq_dout.nonce;
  assign r_tag       = w_rq_dout.tag;
  assign r_exhausted = w_rq_dout.exhausted;
  assign r_overflow  = r_ovf;

endmodule
`default_nettype wire
